// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed storage array.
// Provides byte strobes, a fixed number of PREADY wait states, and PSLVERR on decode miss.
module apb_mem_slave #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            NUM_WORDS   = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_CYCLES = 0
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic                      pwrite_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
    output logic                      pready_o,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pslverr_o
);

    localparam int unsigned           STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W      = $clog2(NUM_WORDS);
    localparam int unsigned           BYTE_SHIFT = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(NUM_WORDS * STRB_W);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK   = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [7:0]            WAIT_LOAD  = 8'(WAIT_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        idx;
    logic                    hit;
    logic                    mem_we;
    logic                    pready;
    logic                    pslverr;
    logic [DATA_WIDTH-1:0]   rdata;

    // Decode works on the setup-phase address so bus changes during ACCESS have no effect.
    // An address below the base wraps the subtraction, hence the explicit lower-bound test.
    always_comb begin
        offset = addr_q - BASE_ADDR;
        idx    = IDX_W'(offset >> BYTE_SHIFT);
        hit    = (addr_q >= BASE_ADDR) && (offset < SPAN) && ((offset & LOW_MASK) == '0);
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        pready  = 1'b0;
        pslverr = 1'b0;
        rdata   = '0;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (psel_i) begin
                    if (penable_i) begin
                        // Access phase without a setup phase: reject at once, stay idle.
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else begin
                        addr_d  = paddr_i;
                        write_d = pwrite_i;
                        wdata_d = pwdata_i;
                        strb_d  = pstrb_i;
                        cnt_d   = WAIT_LOAD;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (penable_i) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        pready  = 1'b1;
                        pslverr = !hit;
                        mem_we  = hit && write_q;
                        if (hit && !write_q) begin
                            rdata = mem_q[idx];
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even if the bus is driven.
    assign pready_o  = pready & arst_ni;
    assign pslverr_o = pslverr & arst_ni;
    assign prdata_o  = rdata & {DATA_WIDTH{arst_ni}};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // NOTE: storage is cleared by reset because readers rely on all words reading 0 afterwards.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with no wait states, one with three.
module tb_apb_mem_slave;

    logic        clk;
    logic        arst_n;
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    int n_vec = 0;
    int n_bad = 0;

    apb_mem_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .arst_ni(arst_n), .psel_i(psel[0]), .penable_i(penable[0]),
        .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
    );

    apb_mem_slave #(.WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .arst_ni(arst_n), .psel_i(psel[1]), .penable_i(penable[1]),
        .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one complete transfer starting just after a rising edge and returns just after
    // the completing edge. Bus inputs are scrambled during ACCESS. cycles = -1 on timeout.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int cycles);
        bit done;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        rdata      = 32'hx;
        err        = 1'bx;
        cycles     = 1;
        done       = 1'b0;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d]   = addr ^ 32'h4;
        pwdata[d]  = ~wdata;
        pstrb[d]   = ~strb;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (pready[d]) begin
                rdata = prdata[d];
                err   = pslverr[d];
                done  = 1'b1;
            end
            @(posedge clk); #1;
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b1; penable[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
                n_bad++;
                $display("FAIL reset_hold dut%0d: got rdy=%b err=%b data=%h want all 0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
                n_bad++;
                $display("FAIL reset_after dut%0d: got rdy=%b err=%b data=%h want all 0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        n_vec++;
        if (cyc !== 2 || err !== 1'b0) begin
            n_bad++; $display("FAIL basic_wr: got cycles=%0d err=%b want 2/0", cyc, err);
        end
        apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (cyc !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL basic_rd: got cycles=%0d err=%b data=%h want 2/0/deadbeef", cyc, err, rd);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, rd, err, cyc);
        apb_xfer(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'h5, rd, err, cyc);
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (rd !== 32'h11BB33DD || err !== 1'b0) begin
            n_bad++; $display("FAIL strb_partial: got %h err=%b want 11bb33dd/0", rd, err);
        end
        apb_xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, rd, err, cyc);
        n_vec++;
        if (err !== 1'b0 || cyc !== 2) begin
            n_bad++; $display("FAIL strb_zero_wr: got cycles=%0d err=%b want 2/0", cyc, err);
        end
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (rd !== 32'h11BB33DD) begin
            n_bad++; $display("FAIL strb_zero_rd: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(1, 1'b1, 32'h8, 32'h13572468, 4'hF, rd, err, cyc);
        n_vec++;
        if (cyc !== 5 || err !== 1'b0) begin
            n_bad++; $display("FAIL wait_wr: got cycles=%0d err=%b want 5/0", cyc, err);
        end
        apb_xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (cyc !== 5 || err !== 1'b0 || rd !== 32'h13572468) begin
            n_bad++;
            $display("FAIL wait_rd: got cycles=%0d err=%b data=%h want 5/0/13572468", cyc, err, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 2) begin
            n_bad++;
            $display("FAIL err_range: got err=%b data=%h cycles=%0d want 1/0/2", err, rd, cyc);
        end
        apb_xfer(0, 1'b1, 32'h2, 32'hCAFEBABE, 4'hF, rd, err, cyc);
        n_vec++;
        if (err !== 1'b1 || cyc !== 2) begin
            n_bad++; $display("FAIL err_misalign: got err=%b cycles=%0d want 1/2", err, cyc);
        end
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (rd !== 32'h11BB33DD || err !== 1'b0) begin
            n_bad++; $display("FAIL err_nochange: got %h err=%b want 11bb33dd/0", rd, err);
        end
        apb_xfer(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 5) begin
            n_bad++;
            $display("FAIL err_wait: got err=%b data=%h cycles=%0d want 1/0/5", err, rd, cyc);
        end
        // Access phase with no setup phase.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h0; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
        @(negedge clk);
        n_vec++;
        if (pready[0] !== 1'b1 || pslverr[0] !== 1'b1 || prdata[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL err_nosetup: got rdy=%b err=%b data=%h want 1/1/0",
                     pready[0], pslverr[0], prdata[0]);
        end
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (rd !== 32'h11BB33DD || err !== 1'b0 || cyc !== 2) begin
            n_bad++;
            $display("FAIL err_nosetup_after: got %h err=%b cycles=%0d want 11bb33dd/0/2", rd, err, cyc);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int cyc;
        apb_xfer(1, 1'b1, 32'h4, 32'h0BADC0DE, 4'hF, rd, err, cyc);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h4; pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pready[1] !== 1'b0) begin
            n_bad++; $display("FAIL abort_wait: got rdy=%b want 0", pready[1]);
        end
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0) begin
            n_bad++; $display("FAIL abort_drop: got rdy=%b err=%b want 0/0", pready[1], pslverr[1]);
        end
        @(posedge clk); #1;
        apb_xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
        n_vec++;
        if (rd !== 32'h0BADC0DE || err !== 1'b0 || cyc !== 5) begin
            n_bad++;
            $display("FAIL abort_next: got %h err=%b cycles=%0d want 0badc0de/0/5", rd, err, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc; logic [31:0] exp;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                exp = {8'(i), 8'(d), 8'hC3, ~8'(i)};
                apb_xfer(d, 1'b1, 32'(i * 4), exp, 4'hF, rd, err, cyc);
                n_vec++;
                if (cyc !== (d == 0 ? 2 : 5) || err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_wr dut%0d w%0d: got cycles=%0d err=%b want %0d/0",
                             d, i, cyc, err, (d == 0 ? 2 : 5));
                end
            end
            for (int i = 0; i < 16; i++) begin
                exp = {8'(i), 8'(d), 8'hC3, ~8'(i)};
                apb_xfer(d, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, cyc);
                n_vec++;
                if (rd !== exp || cyc !== (d == 0 ? 2 : 5) || err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_rd dut%0d w%0d: got %h cycles=%0d err=%b want %h/%0d/0",
                             d, i, rd, cyc, err, exp, (d == 0 ? 2 : 5));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cyc;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'hC; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        n_vec++;
        if ({pready[1], pslverr[1], prdata[1]} !== 34'd0) begin
            n_bad++;
            $display("FAIL rstmid_out: got rdy=%b err=%b data=%h want all 0",
                     pready[1], pslverr[1], prdata[1]);
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                apb_xfer(d, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, cyc);
                n_vec++;
                if (rd !== 32'h0 || err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rstmid_clear dut%0d w%0d: got %h err=%b want 0/0", d, i, rd, err);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = '0;
            pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0;
        end
        test_reset();
        test_basic();
        test_strobes();
        test_wait_states();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
